// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the parametrised UART receiver   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int MAX_PAYLOAD_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_PUSH   = 3'd5
    } rx_state_t;

    // Data is sized for the widest legal frame; narrower frames zero-fill the top.
    typedef struct packed {
        logic [MAX_PAYLOAD_BITS-1:0] data;
        logic                        parity_err;
        logic                        frame_err;
        logic                        brk;
    } rx_entry_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_fifo : synchronous show-ahead FIFO with occupancy count            |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == FULL_COUNT);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_param : configurable-frame UART receiver with voting and FIFO      |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 48_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    input  logic                          rx_overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int MID            = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT);

    logic                    rxd_meta_q, rxd_sync_q;
    rx_state_t               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    smp0_q, smp0_d, smp1_q, smp1_d;
    logic                    perr_q, perr_d, ferr_q, ferr_d;
    logic                    overrun_q, overrun_d;

    logic                    w_vote, w_at_vote, w_wrap, w_push, w_full, w_empty, w_drop;
    rx_entry_t               w_entry, w_head;
    logic [$bits(rx_entry_t)-1:0] w_fifo_data;

    assign w_wrap    = (cnt_q == CW'(CYCLES_PER_BIT - 1));
    assign w_at_vote = (cnt_q == CW'(MID + 1));
    // Third sample is the live synchronised value at the vote point.
    assign w_vote    = (smp0_q & smp1_q) | (smp0_q & rxd_sync_q) | (smp1_q & rxd_sync_q);
    assign w_push    = (state_q == ST_PUSH);
    assign rx_valid  = !w_empty;
    assign w_drop    = w_push && w_full && !(rx_valid && rx_ready);

    always_comb begin
        state_d   = state_q;
        cnt_d     = w_wrap ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        data_d    = data_q;
        smp0_d    = (cnt_q == CW'(MID - 1)) ? rxd_sync_q : smp0_q;
        smp1_d    = (cnt_q == CW'(MID))     ? rxd_sync_q : smp1_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (uart_rx_en && !rxd_sync_q) begin
                    state_d = ST_START;
                    data_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (w_at_vote && w_vote) begin
                    state_d = ST_IDLE;
                end else if (w_wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_at_vote) begin
                    data_d = {w_vote, data_q[PAYLOAD_BITS-1:1]};
                    bit_d  = bit_q + 4'd1;
                end
                if (w_wrap && bit_q == 4'(PAYLOAD_BITS)) begin
                    bit_d   = '0;
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_at_vote) begin
                    perr_d = (^data_q) ^ w_vote ^ (PARITY == PAR_ODD);
                end
                if (w_wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_at_vote) begin
                    if (!w_vote) begin
                        ferr_d = 1'b1;
                    end
                    // Leave mid-bit on the final stop so a back-to-back start is not missed.
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        state_d = ST_PUSH;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PUSH: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!uart_rx_en && state_q != ST_IDLE && state_q != ST_PUSH) begin
            state_d = ST_IDLE;
        end

        if (rx_overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (w_drop) begin
            overrun_d = 1'b1;
        end

        w_entry                             = '0;
        w_entry.data[PAYLOAD_BITS-1:0]      = data_q;
        w_entry.parity_err                  = perr_q;
        w_entry.frame_err                   = ferr_q;
        w_entry.brk                         = (data_q == '0) && ferr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            smp0_q     <= 1'b1;
            smp1_q     <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (rx_ready),
        .o_data  (w_fifo_data),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head        = rx_entry_t'(w_fifo_data);
    assign rx_data       = w_head.data[PAYLOAD_BITS-1:0];
    assign rx_parity_err = w_head.parity_err;
    assign rx_frame_err  = w_head.frame_err;
    assign rx_break      = w_head.brk;
    assign rx_overrun    = overrun_q;

    generate
        if (PAYLOAD_BITS < MAX_PAYLOAD_BITS) begin : g_unused_pad
            logic w_unused_hi;
            assign w_unused_hi = |w_head.data[MAX_PAYLOAD_BITS-1:PAYLOAD_BITS];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_param : directed bench with a frame-level FIFO scoreboard       |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_uart_rx_param;

    localparam int CPB   = 10;
    localparam int M     = CPB / 2;
    localparam int DEPTH = 4;
    // Line fall to rx_valid: 2 sync + 1 detect, stop vote at M+1, then PUSH and write.
    localparam int LAT_N = 3 + CPB * 9  + M + 3;
    localparam int LAT_E = 3 + CPB * 10 + M + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       rxd_e = 1'b1, en_e = 1'b1, rdy_e = 1'b0, clr_e = 1'b0;
    logic [7:0] data_e;
    logic       pe_e, fe_e, brk_e, valid_e, ovr_e;
    logic [2:0] cnt_e;

    logic       rxd_n = 1'b1, en_n = 1'b1, rdy_n = 1'b0, clr_n = 1'b0;
    logic [7:0] data_n;
    logic       pe_n, fe_n, brk_n, valid_n, ovr_n;
    logic [2:0] cnt_n;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
        .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(DEPTH)
    ) dut_e (
        .clk(clk), .reset(reset), .uart_rxd(rxd_e), .uart_rx_en(en_e),
        .rx_data(data_e), .rx_parity_err(pe_e), .rx_frame_err(fe_e),
        .rx_break(brk_e), .rx_valid(valid_e), .rx_ready(rdy_e),
        .rx_overrun(ovr_e), .rx_overrun_clr(clr_e), .fifo_count(cnt_e)
    );

    uart_rx_param #(
        .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
        .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(DEPTH)
    ) dut_n (
        .clk(clk), .reset(reset), .uart_rxd(rxd_n), .uart_rx_en(en_n),
        .rx_data(data_n), .rx_parity_err(pe_n), .rx_frame_err(fe_n),
        .rx_break(brk_n), .rx_valid(valid_n), .rx_ready(rdy_n),
        .rx_overrun(ovr_n), .rx_overrun_clr(clr_n), .fifo_count(cnt_n)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } ent_t;

    typedef struct {
        longint due;
        ent_t   e;
    } sched_t;

    ent_t   mq[$];
    sched_t pend[$];
    logic   m_ovr = 1'b0;
    longint cyc = 0;
    logic   rdy_edge = 1'b0;
    logic   clr_edge = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= rdy_e;
        clr_edge <= clr_e;
    end

    // Scoreboard for dut_e: frames land in an ideal FIFO at their predicted cycle.
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            pend.delete();
            m_ovr = 1'b0;
        end else begin
            logic set_ovr;
            set_ovr = 1'b0;
            if (rdy_edge && mq.size() > 0) void'(mq.pop_front());
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                if (mq.size() < DEPTH) mq.push_back(pend[0].e);
                else set_ovr = 1'b1;
                void'(pend.pop_front());
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (clr_edge) m_ovr = 1'b0;

            chk("m_valid", valid_e, mq.size() > 0);
            chk("m_count", cnt_e, mq.size());
            chk("m_overrun", ovr_e, m_ovr);
            if (mq.size() > 0) begin
                chk("m_data", data_e, mq[0].d);
                chk("m_parity_err", pe_e, mq[0].pe);
                chk("m_frame_err", fe_e, mq[0].fe);
                chk("m_break", brk_e, mq[0].brk);
            end
        end
    end

    task automatic drive_frame(input bit to_n, input logic [10:0] bits, input int nb, input int flip_bit);
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < CPB; k++) begin
                logic v;
                v = bits[i];
                if (i == flip_bit && k == M) v = ~v;
                if (to_n) rxd_n = v;
                else rxd_e = v;
                @(negedge clk);
            end
        end
    endtask

    task automatic send_e(input logic [7:0] d, input logic pbit, input int flip_bit);
        sched_t s;
        @(negedge clk);
        s.due   = cyc + LAT_E;
        s.e.d   = d;
        s.e.pe  = (^d) ^ pbit;
        s.e.fe  = 1'b0;
        s.e.brk = 1'b0;
        pend.push_back(s);
        drive_frame(1'b0, {1'b1, pbit, d, 1'b0}, 11, flip_bit);
    endtask

    task automatic wait_valid_e(input string name, input int maxc);
        int n;
        n = 0;
        while (!valid_e && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!valid_e) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=0 required=1", name);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        longint t0;
        int     n;

        repeat (3) @(negedge clk);
        chk("rst_valid_e", valid_e, 0);
        chk("rst_data_e", data_e, 0);
        chk("rst_count_e", cnt_e, 0);
        chk("rst_flags_e", {pe_e, fe_e, brk_e, ovr_e}, 0);
        chk("rst_valid_n", valid_n, 0);
        chk("rst_count_n", cnt_n, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        idle(5);

        // 8N1 0xA5 with exact latency
        @(negedge clk);
        t0 = cyc;
        drive_frame(1'b1, {1'b1, 8'hA5, 1'b0}, 10, -1);
        n = 0;
        while (!valid_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a5_latency", 32'(cyc - t0), 101);
        chk("a5_data", data_n, 8'hA5);
        chk("a5_flags", {pe_n, fe_n, brk_n}, 0);
        chk("a5_count", cnt_n, 1);
        rdy_n = 1'b1;
        @(negedge clk);
        rdy_n = 1'b0;
        chk("a5_popped", cnt_n, 0);

        // break: 12 bit times low, then the rebuilt frame 0xFE
        @(negedge clk);
        rxd_n = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        rxd_n = 1'b1;
        n = 0;
        while (cnt_n != 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("brk_count", cnt_n, 2);
        chk("brk_data", data_n, 8'h00);
        chk("brk_flags", {pe_n, fe_n, brk_n}, 3'b011);
        rdy_n = 1'b1;
        @(negedge clk);
        rdy_n = 1'b0;
        chk("brk2_data", data_n, 8'hFE);
        chk("brk2_flags", {pe_n, fe_n, brk_n}, 3'b000);
        rdy_n = 1'b1;
        @(negedge clk);
        rdy_n = 1'b0;
        idle(30);
        chk("brk_drained", cnt_n, 0);

        // even parity
        rdy_e = 1'b1;
        send_e(8'h03, 1'b1, -1);
        wait_valid_e("par1_wait", 50);
        chk("par1_data", data_e, 8'h03);
        chk("par1_err", pe_e, 1);
        idle(2 * CPB);
        send_e(8'h03, 1'b0, -1);
        wait_valid_e("par0_wait", 50);
        chk("par0_data", data_e, 8'h03);
        chk("par0_err", pe_e, 0);
        idle(2 * CPB);
        send_e(8'hC3, 1'b0, -1);
        idle(2 * CPB);
        send_e(8'h80, 1'b0, -1);
        idle(2 * CPB);

        // glitch on idle line
        @(negedge clk);
        rxd_e = 1'b0;
        idle(3);
        rxd_e = 1'b1;
        idle(30);
        chk("glitch_none", {valid_e, cnt_e}, 0);

        // one flipped sample mid data bit
        send_e(8'h96, 1'b0, 5);
        wait_valid_e("flip_wait", 50);
        chk("flip_data", data_e, 8'h96);
        idle(2 * CPB);

        // overrun
        rdy_e = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] d;
            d = 8'(8'h11 * i);
            send_e(d, ^d, -1);
            idle(CPB);
        end
        idle(5);
        chk("ovr_count", cnt_e, 4);
        chk("ovr_flag", ovr_e, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_pop_data", data_e, 8'(8'h11 * i));
            rdy_e = 1'b1;
            @(negedge clk);
            rdy_e = 1'b0;
        end
        chk("ovr_empty", cnt_e, 0);
        chk("ovr_sticky", ovr_e, 1);
        clr_e = 1'b1;
        @(negedge clk);
        clr_e = 1'b0;
        chk("ovr_cleared", ovr_e, 0);

        // enable dropped mid frame
        rdy_e = 1'b1;
        @(negedge clk);
        drive_frame(1'b0, {1'b1, 1'b0, 8'h00, 1'b0}, 4, -1);
        en_e = 1'b0;
        drive_frame(1'b0, {4'b0000, 1'b1, 1'b0, 5'b00000}, 7, -1);
        rxd_e = 1'b1;
        idle(2 * CPB);
        en_e = 1'b1;
        idle(2 * CPB);
        chk("en_drop_none", {valid_e, cnt_e}, 0);

        // reset mid data with an entry waiting
        rdy_e = 1'b0;
        send_e(8'h3C, 1'b0, -1);
        wait_valid_e("pre_rst_wait", 50);
        idle(CPB);
        @(negedge clk);
        drive_frame(1'b0, {1'b1, 1'b0, 8'h3C, 1'b0}, 4, -1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", valid_e, 0);
        chk("arst_data", data_e, 0);
        chk("arst_count", cnt_e, 0);
        chk("arst_flags", {pe_e, fe_e, brk_e, ovr_e}, 0);
        rxd_e = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        idle(2 * CPB);
        rdy_e = 1'b1;
        send_e(8'h5A, 1'b0, -1);
        wait_valid_e("post_rst_wait", 50);
        chk("post_rst_data", data_e, 8'h5A);
        chk("post_rst_flags", {pe_e, fe_e, brk_e}, 0);
        idle(3 * CPB);
        chk("end_empty", cnt_e, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
